axis_requantizer: RTL

- Consumes the widened product stream produced by the team's AXIS weight multiplier: 16 lanes of 16-bit unsigned products per beat.
- Narrows each lane back to 8 bits with a programmable right shift, optional round-half-up, and saturation.
- Emits a 128-bit AXIS stream toward the next DSP stage or the MM2S/S2MM DMA.
- Provides full AXIS backpressure through a 2-entry skid buffer, a sticky saturation flag and a packet counter.

---
 rtl/axis_requantizer.sv | 88 ++++++++
 1 files changed

// File: rtl/axis_requantizer.sv
// axis_requantizer: narrows 16x16-bit AXIS product lanes to 8 bits with shift, round-half-up and saturation
//   CLK, resetn         clock and synchronous active-low reset
//   s_axis_*            256-bit input stream, lane i at [16i+:16]; shift/round_en sampled per accepted beat
//   m_axis_*            128-bit output stream, lane i at [8i+:8], behind a main + skid register pair
//   sat_flag, sat_clear sticky "some kept lane saturated" flag and its clear (a same-edge set wins)
//   pkt_count           completed output packets, wrapping
module axis_requantizer #(
  parameter int SAMPLES       = 16,
  parameter int ISAMPLE_WIDTH = 16,
  parameter int OSAMPLE_WIDTH = 8,
  parameter int SHIFT_WIDTH   = 4,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                               CLK,
  input  logic                               resetn,
  input  logic [SAMPLES*ISAMPLE_WIDTH-1:0]   s_axis_tdata,
  input  logic [SAMPLES-1:0]                 s_axis_tkeep,
  input  logic                               s_axis_tvalid,
  output logic                               s_axis_tready,
  input  logic                               s_axis_tlast,
  input  logic [SHIFT_WIDTH-1:0]             shift,
  input  logic                               round_en,
  input  logic                               sat_clear,
  output logic [SAMPLES*OSAMPLE_WIDTH-1:0]   m_axis_tdata,
  output logic [SAMPLES-1:0]                 m_axis_tkeep,
  output logic                               m_axis_tvalid,
  input  logic                               m_axis_tready,
  output logic                               m_axis_tlast,
  output logic                               sat_flag,
  output logic [CNT_WIDTH-1:0]               pkt_count
);
  localparam int SW = ISAMPLE_WIDTH + 1;
  localparam int OW = SAMPLES * OSAMPLE_WIDTH;
  localparam int BW = 1 + SAMPLES + OW;
  logic [SW-1:0] rnd;
  logic [SAMPLES-1:0] lane_sat;
  logic [OW-1:0] beat_data;
  logic [BW-1:0] beat, main_q, main_d, skid_q, skid_d;
  logic main_valid_q, main_valid_d, skid_valid_q, skid_valid_d, ready_q, sat_q, sat_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic accept, out_xfer, load_skid;
  // one extra bit of headroom so x + rounding constant never wraps
  assign rnd = (round_en && shift != '0) ? SW'(1) << (shift - SHIFT_WIDTH'(1)) : '0;
  for (genvar i = 0; i < SAMPLES; i++) begin : g_lane
    logic [SW-1:0] t;
    assign t = ({1'b0, s_axis_tdata[i*ISAMPLE_WIDTH +: ISAMPLE_WIDTH]} + rnd) >> shift;
    assign lane_sat[i] = s_axis_tkeep[i] && |t[SW-1:OSAMPLE_WIDTH];
    assign beat_data[i*OSAMPLE_WIDTH +: OSAMPLE_WIDTH] =
      !s_axis_tkeep[i] ? '0 : lane_sat[i] ? '1 : t[OSAMPLE_WIDTH-1:0];
  end
  assign beat = {s_axis_tlast, s_axis_tkeep, beat_data};
  assign accept = s_axis_tvalid && ready_q;
  assign out_xfer = main_valid_q && m_axis_tready;
  // a beat only parks in skid when main is holding a stalled beat
  assign load_skid = accept && main_valid_q && !m_axis_tready;
  always_comb begin
    main_d = skid_valid_q ? (out_xfer ? skid_q : main_q) : (accept && !load_skid) ? beat : main_q;
    main_valid_d = skid_valid_q || accept || (main_valid_q && !m_axis_tready);
    skid_d = load_skid ? beat : skid_q;
    skid_valid_d = skid_valid_q ? !out_xfer : load_skid;
    sat_d = (accept && |lane_sat) || (sat_q && !sat_clear);
    cnt_d = cnt_q + CNT_WIDTH'(out_xfer && main_q[BW-1]);
  end
  always_ff @(posedge CLK) begin
    if (!resetn) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      ready_q      <= 1'b0;
      sat_q        <= 1'b0;
      cnt_q        <= '0;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      ready_q      <= !skid_valid_d;
      sat_q        <= sat_d;
      cnt_q        <= cnt_d;
    end
  end
  assign {m_axis_tlast, m_axis_tkeep, m_axis_tdata} = main_q;
  assign m_axis_tvalid = main_valid_q;
  assign s_axis_tready = ready_q;
  assign sat_flag = sat_q;
  assign pkt_count = cnt_q;
endmodule
